// File: rtl/mul_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_pkg
// Description : State encoding and counter sizing helper for mul_seq_nbit.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, minimum 1, so a counter can always hold at least 0..1.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : mul_seq_pkg
`default_nettype wire

// File: rtl/adder_nbit.sv
`default_nettype none
// ============================================================================
// Module      : adder_nbit
// Description : Plain WIDTH-bit modulo adder used by the accumulate path.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_nbit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule : adder_nbit
`default_nettype wire

// File: rtl/mul_seq_nbit.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_nbit
// Description : Radix-2 sequential shift-add multiplier, signed/unsigned,
//               valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_nbit
    import mul_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit LOW_ONLY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P
);

    localparam int                 c_CNT_W   = clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [2*WIDTH-1:0] c_P_MASK  = LOW_ONLY ?
        {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : {(2*WIDTH){1'b1}};

    state_t               r_state;
    state_t               w_state_next;

    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_p;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_neg;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_sum;
    logic [2*WIDTH-1:0]   w_p_signed;
    logic [2*WIDTH-1:0]   w_p_final;
    logic                 w_accept;
    logic                 w_last_step;

    // Negating the most-negative value wraps to 2^(WIDTH-1), which is exactly
    // the required unsigned magnitude.
    assign w_mag_a = (signed_mode && A[WIDTH-1]) ? -A : A;
    assign w_mag_b = (signed_mode && B[WIDTH-1]) ? -B : B;
    assign w_neg   = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);

    assign w_accept    = (r_state == IDLE) && in_valid;
    assign w_last_step = (r_cnt == c_LAST);

    assign w_addend = r_mplier[0] ? r_mcand : '0;

    adder_nbit #(
        .WIDTH (2*WIDTH)
    ) u_acc_adder (
        .a   (r_acc),
        .b   (w_addend),
        .sum (w_sum)
    );

    assign w_p_signed = r_neg ? -r_acc : r_acc;
    assign w_p_final  = w_p_signed & c_P_MASK;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign P         = r_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_state_next = BUSY;
            BUSY:    if (w_last_step) w_state_next = DONE;
            DONE:    if (out_ready)   w_state_next = IDLE;
            default:                  w_state_next = IDLE;
        endcase
    end

    // WIDTH add steps while the counter runs 0..WIDTH-1; the extra BUSY cycle
    // at count WIDTH applies the sign and publishes the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_p      <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= w_neg;
        end else if (r_state == BUSY) begin
            if (w_last_step) begin
                r_p <= w_p_final;
            end else begin
                r_acc    <= w_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + c_CNT_ONE;
            end
        end
    end

endmodule : mul_seq_nbit
`default_nettype wire

// File: tb/tb_mul_seq_nbit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_nbit
// Description : Directed self-checking bench, full and low-only WIDTH=8 units
//               driven in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_nbit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        signed_mode;
    logic        out_ready;
    logic        in_ready_f, out_valid_f, in_ready_l, out_valid_l;
    logic [15:0] p_f, p_l;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mul_seq_nbit #(.WIDTH(8), .LOW_ONLY(1'b0)) u_dut_full (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f),
        .A(A), .B(B), .signed_mode(signed_mode), .out_valid(out_valid_f),
        .out_ready(out_ready), .P(p_f)
    );

    mul_seq_nbit #(.WIDTH(8), .LOW_ONLY(1'b1)) u_dut_low (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
        .A(A), .B(B), .signed_mode(signed_mode), .out_valid(out_valid_l),
        .out_ready(out_ready), .P(p_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair, scramble inputs while busy, and check latency,
    // product, low-only product and the return to IDLE.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sm, input logic [15:0] exp, input int hold);
        int k;
        A = a; B = b; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        chk({tag, "_busy_rdy"}, {31'd0, in_ready_f}, 32'd0);
        k = 0;
        while (!out_valid_f && k < 40) begin
            in_valid = 1'b1; A = 8'($urandom); B = 8'($urandom); signed_mode = 1'($urandom);
            tick();
            k++;
        end
        chk({tag, "_latency"}, k, 9);
        chk({tag, "_p"}, {16'd0, p_f}, {16'd0, exp});
        chk({tag, "_p_low"}, {16'd0, p_l}, {24'd0, exp[7:0]});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; A = 8'($urandom); B = 8'($urandom);
            tick();
            chk({tag, "_hold"}, {15'd0, out_valid_f, p_f}, {15'd0, 1'b1, exp});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, in_ready_f, out_valid_f}, 32'd2);
        chk({tag, "_p_kept"}, {16'd0, p_f}, {16'd0, exp});
    endtask

    initial begin
        bit seen;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; signed_mode = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("reset_state", {13'd0, in_ready_f, out_valid_f, in_ready_l, p_f}, {13'd0, 3'b101, 16'd0});
        rst = 1'b0;
        tick();

        do_op("u13x11",    8'd13,  8'd11,  1'b0, 16'h008F, 0);
        do_op("s_m3x5",    8'hFD,  8'h05,  1'b1, 16'hFFF1, 0);
        do_op("s_80x80",   8'h80,  8'h80,  1'b1, 16'h4000, 0);
        do_op("u_ffxff",   8'hFF,  8'hFF,  1'b0, 16'hFE01, 0);
        do_op("s_ffxff",   8'hFF,  8'hFF,  1'b1, 16'h0001, 0);
        do_op("s_80x7f",   8'h80,  8'h7F,  1'b1, 16'hC080, 0);
        do_op("s_80x01",   8'h80,  8'h01,  1'b1, 16'hFF80, 0);
        do_op("u_80x80",   8'h80,  8'h80,  1'b0, 16'h4000, 0);
        do_op("s_02xff",   8'h02,  8'hFF,  1'b1, 16'hFFFE, 0);
        do_op("u_02xff",   8'h02,  8'hFF,  1'b0, 16'h01FE, 0);
        do_op("s_0xff",    8'h00,  8'hFF,  1'b1, 16'h0000, 0);
        do_op("u_7fx7f",   8'h7F,  8'h7F,  1'b0, 16'h3F01, 20);

        // Abort mid-BUSY: the result must never appear.
        A = 8'h55; B = 8'h33; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_state", {13'd0, in_ready_f, out_valid_f, in_ready_l, p_f}, {13'd0, 3'b101, 16'd0});
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (out_valid_f || out_valid_l) seen = 1'b1;
        end
        chk("abort_no_valid", {31'd0, seen}, 32'd0);

        do_op("u_7x6",     8'd7,   8'd6,   1'b0, 16'h002A, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_mul_seq_nbit
`default_nettype wire
